// File: rtl/lut_cfg_loader_if.sv
// lut_cfg_loader_if
//   Bundles the serial bitstream handshake and the committed-word outputs of
//   lut_cfg_loader.
//   master : bitstream source (drives bit_in/bit_valid/bit_sof, observes the rest)
//   slave  : the loader itself
//   Signals:
//     bit_in, bit_valid, bit_sof : serial bit, its qualifier, start-of-frame flag
//     bit_ready                  : loader accepts a bit this cycle
//     config_out [CFG_WIDTH]     : committed word feeding the LUT config_in
//     cen                        : one-cycle commit strobe to the LUT
//     done, err                  : sticky status of the last frame
//     busy                       : frame in progress
interface lut_cfg_loader_if #(
  parameter int CFG_WIDTH = 33
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_sof;
  logic                 bit_ready;
  logic [CFG_WIDTH-1:0] config_out;
  logic                 cen;
  logic                 done;
  logic                 err;
  logic                 busy;

  modport master (
    output bit_in, bit_valid, bit_sof,
    input  bit_ready, config_out, cen, done, err, busy
  );

  modport slave (
    input  bit_in, bit_valid, bit_sof,
    output bit_ready, config_out, cen, done, err, busy
  );
endinterface

// File: rtl/lut_cfg_loader.sv
// lut_cfg_loader
//   Serial configuration loader for the fracturable LUT. Shifts a frame of
//   CFG_WIDTH data bits (MSB first) plus one even-parity bit into a shadow
//   register, then commits the word to config_out with a one-cycle cen pulse.
//   Bad or aborted frames leave config_out untouched.
//   Ports:
//     cclk : configuration clock
//     rst  : asynchronous active-high reset
//     bus  : lut_cfg_loader_if slave modport (handshake in, committed word/status out)
//
//   state  | meaning
//   IDLE   | waiting for a bit with bit_sof; stray bits are consumed and dropped
//   LOAD   | shifting data bits, accumulating parity
//   CHECK  | parity bit received; decide commit or error
//   COMMIT | config_out holds the new word, cen high for this cycle
module lut_cfg_loader #(
  parameter int INPUTS    = 4,
  parameter int MEM_SIZE  = 2**INPUTS,
  parameter int CFG_WIDTH = 2*MEM_SIZE+1
) (
  input logic           cclk,
  input logic           rst,
  lut_cfg_loader_if.slave bus
);

  localparam int CW = $clog2(CFG_WIDTH+2);
  // Count value just before the parity bit arrives (all data bits taken).
  localparam logic [CW-1:0] LAST_DATA = CW'(CFG_WIDTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_CHECK  = 2'd2,
    S_COMMIT = 2'd3
  } state_t;

  state_t               r_state;
  logic [CFG_WIDTH-1:0] r_shadow;
  logic [CFG_WIDTH-1:0] r_config;
  logic [CW-1:0]        r_count;
  logic                 r_parity;
  logic                 r_bit_ready;
  logic                 r_cen;
  logic                 r_done;
  logic                 r_err;
  logic                 r_busy;

  logic w_xfer;
  logic w_start;

  assign w_xfer  = bus.bit_valid && r_bit_ready;
  // ready is low in CHECK/COMMIT, so a start can only come from IDLE or LOAD.
  assign w_start = w_xfer && bus.bit_sof;

  always_ff @(posedge cclk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shadow    <= '0;
      r_config    <= '0;
      r_count     <= '0;
      r_parity    <= 1'b0;
      r_bit_ready <= 1'b1;
      r_cen       <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
    end else if (w_start) begin
      // New frame, or restart of an in-flight one; the sof bit is data bit 0.
      r_state     <= S_LOAD;
      r_shadow    <= {r_shadow[CFG_WIDTH-2:0], bus.bit_in};
      r_count     <= CW'(1);
      r_parity    <= bus.bit_in;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_busy      <= 1'b1;
      r_bit_ready <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cen <= 1'b0;
        end
        S_LOAD: begin
          if (w_xfer) begin
            r_count  <= r_count + CW'(1);
            r_parity <= r_parity ^ bus.bit_in;
            if (r_count == LAST_DATA) begin
              // Parity bit: folded into the running parity, not into the shadow.
              r_state     <= S_CHECK;
              r_bit_ready <= 1'b0;
            end else begin
              r_shadow <= {r_shadow[CFG_WIDTH-2:0], bus.bit_in};
            end
          end
        end
        S_CHECK: begin
          if (!r_parity) begin
            r_state  <= S_COMMIT;
            r_config <= r_shadow;
            r_cen    <= 1'b1;
          end else begin
            r_state     <= S_IDLE;
            r_err       <= 1'b1;
            r_busy      <= 1'b0;
            r_bit_ready <= 1'b1;
          end
        end
        S_COMMIT: begin
          r_state     <= S_IDLE;
          r_cen       <= 1'b0;
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_bit_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_cen       <= 1'b0;
          r_busy      <= 1'b0;
          r_bit_ready <= 1'b1;
        end
      endcase
    end
  end

  assign bus.bit_ready  = r_bit_ready;
  assign bus.config_out = r_config;
  assign bus.cen        = r_cen;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_lut_cfg_loader.sv
// tb_lut_cfg_loader
//   Directed bench for lut_cfg_loader at default parameters (33-bit word).
//   Bits are driven on the falling edge and outputs sampled on the falling edge.
module tb_lut_cfg_loader;

  localparam int CFG = 33;

  logic cclk = 1'b0;
  logic rst  = 1'b1;
  int   vectors     = 0;
  int   miscompares = 0;
  int   cen_cnt     = 0;

  lut_cfg_loader_if #(.CFG_WIDTH(CFG)) bif ();

  lut_cfg_loader #(.INPUTS(4)) dut (
    .cclk (cclk),
    .rst  (rst),
    .bus  (bif.slave)
  );

  always #5 cclk = ~cclk;

  always @(negedge cclk) if (bif.cen === 1'b1) cen_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic checkw(input string tag, input logic [CFG-1:0] obs, input logic [CFG-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic checki(input string tag, input int obs, input int exp);
    vectors++;
    assert (obs == exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Presents one bit from a falling edge; it transfers on the next rising edge
  // where bit_ready is high.
  task automatic send_bit(input logic b, input logic sof);
    int n;
    @(negedge cclk);
    bif.bit_in    = b;
    bif.bit_valid = 1'b1;
    bif.bit_sof   = sof;
    n = 0;
    while (bif.bit_ready !== 1'b1 && n < 8) begin
      @(negedge cclk);
      n++;
    end
    if (n >= 8) begin
      vectors++;
      miscompares++;
      $error("FAIL ready_timeout: got bit_ready=%b expected 1", bif.bit_ready);
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int j = 0; j < k; j++) begin
      @(negedge cclk);
      bif.bit_valid = 1'b0;
      bif.bit_sof   = 1'b0;
    end
  endtask

  // Full frame; with gaps enabled, idle cycles are sprinkled between bits.
  task automatic send_frame(input logic [CFG-1:0] w, input logic par, input logic gaps);
    for (int i = CFG-1; i >= 0; i--) begin
      if (gaps) idle_cycles(((i % 3) == 0 ? 1 : 0) + ((i % 7) == 0 ? 1 : 0));
      send_bit(w[i], i == CFG-1);
    end
    if (gaps) idle_cycles(2);
    send_bit(par, 1'b0);
  endtask

  // Called right after the parity bit has been presented (edge N is next).
  task automatic expect_commit(input string t, input logic [CFG-1:0] w, input logic hold);
    int c0;
    int not_ready;
    c0 = cen_cnt;
    not_ready = 0;
    @(negedge cclk);                       // after edge N: CHECK
    if (hold) bif.bit_sof = 1'b1;
    else      bif.bit_valid = 1'b0;
    if (bif.bit_ready === 1'b0) not_ready++;
    check1({t, "_check_cen"},  bif.cen,  1'b0);
    check1({t, "_check_busy"}, bif.busy, 1'b1);
    @(negedge cclk);                       // after edge N+1: COMMIT
    if (bif.bit_ready === 1'b0) not_ready++;
    check1({t, "_commit_cen"},  bif.cen,  1'b1);
    checkw({t, "_commit_cfg"},  bif.config_out, w);
    check1({t, "_commit_done"}, bif.done, 1'b0);
    @(negedge cclk);                       // after edge N+2: IDLE
    bif.bit_valid = 1'b0;
    bif.bit_sof   = 1'b0;
    if (bif.bit_ready === 1'b0) not_ready++;
    check1({t, "_after_cen"},   bif.cen,  1'b0);
    check1({t, "_after_done"},  bif.done, 1'b1);
    check1({t, "_after_err"},   bif.err,  1'b0);
    check1({t, "_after_busy"},  bif.busy, 1'b0);
    checkw({t, "_after_cfg"},   bif.config_out, w);
    checki({t, "_cen_pulses"},  cen_cnt - c0, 1);
    checki({t, "_ready_low"},   not_ready, 2);
  endtask

  initial begin
    logic [CFG-1:0] w;
    int c0;

    bif.bit_in    = 1'b0;
    bif.bit_valid = 1'b0;
    bif.bit_sof   = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge cclk);
    check1("rst_ready", bif.bit_ready, 1'b1);
    check1("rst_busy",  bif.busy,      1'b0);
    check1("rst_done",  bif.done,      1'b0);
    check1("rst_err",   bif.err,       1'b0);
    check1("rst_cen",   bif.cen,       1'b0);
    checkw("rst_cfg",   bif.config_out, 33'h0);
    rst = 1'b0;

    // Good frame: 33'h1_AAAA_5555 has 17 ones, parity bit 1.
    send_frame(33'h1_AAAA_5555, 1'b1, 1'b0);
    expect_commit("good", 33'h1_AAAA_5555, 1'b0);

    // Commit 33'h0_1234_5678 (13 ones, parity 1), then a bad-parity frame.
    send_frame(33'h0_1234_5678, 1'b1, 1'b0);
    expect_commit("good2", 33'h0_1234_5678, 1'b0);
    c0 = cen_cnt;
    send_frame(33'h1_AAAA_5555, 1'b0, 1'b0);
    @(negedge cclk);
    bif.bit_valid = 1'b0;
    check1("perr_check_err",  bif.err,  1'b0);
    check1("perr_check_busy", bif.busy, 1'b1);
    @(negedge cclk);
    check1("perr_err",   bif.err,  1'b1);
    check1("perr_done",  bif.done, 1'b0);
    check1("perr_busy",  bif.busy, 1'b0);
    check1("perr_ready", bif.bit_ready, 1'b1);
    @(negedge cclk);
    checkw("perr_cfg",   bif.config_out, 33'h0_1234_5678);
    checki("perr_no_cen", cen_cnt - c0, 0);
    check1("perr_err_sticky", bif.err, 1'b1);

    // Mid-frame restart: 10 garbage bits then a real frame (16 ones, parity 0).
    w = 33'h1_3C5A_9E01;
    send_bit(1'b1, 1'b1);
    for (int i = 1; i < 10; i++) send_bit(w[i], 1'b0);
    send_frame(33'h0_FFFF_0000, 1'b0, 1'b0);
    expect_commit("restart", 33'h0_FFFF_0000, 1'b0);

    // Gaps on bit_valid and valid+sof held through CHECK/COMMIT (17 ones, parity 1).
    send_frame(33'h1_0F0F_F0F0, 1'b1, 1'b1);
    expect_commit("gaps", 33'h1_0F0F_F0F0, 1'b1);
    @(negedge cclk);
    check1("gaps_no_extra_busy", bif.busy, 1'b0);
    check1("gaps_no_extra_done", bif.done, 1'b1);

    // Stray bits in IDLE are swallowed.
    for (int i = 0; i < 5; i++) begin
      send_bit(i[0], 1'b0);
      @(negedge cclk);
      check1("stray_busy", bif.busy, 1'b0);
    end
    bif.bit_valid = 1'b0;
    check1("stray_done", bif.done, 1'b1);
    checkw("stray_cfg",  bif.config_out, 33'h1_0F0F_F0F0);

    // Reset in the middle of a frame, away from any clock edge.
    w = 33'h1_AAAA_5555;
    for (int i = CFG-1; i > CFG-21; i--) send_bit(w[i], i == CFG-1);
    @(negedge cclk);
    bif.bit_valid = 1'b0;
    check1("mid_busy", bif.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    check1("arst_busy",  bif.busy,      1'b0);
    check1("arst_ready", bif.bit_ready, 1'b1);
    check1("arst_done",  bif.done,      1'b0);
    check1("arst_err",   bif.err,       1'b0);
    check1("arst_cen",   bif.cen,       1'b0);
    checkw("arst_cfg",   bif.config_out, 33'h0);
    @(negedge cclk);
    rst = 1'b0;

    // 33'h0_5A5A_A5A5 has 16 ones, parity 0.
    send_frame(33'h0_5A5A_A5A5, 1'b0, 1'b0);
    expect_commit("post_rst", 33'h0_5A5A_A5A5, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
